// File: rtl/instr_queue.sv
// Dual-slot instruction queue between the realign stage and decode.
// Circular buffer accepting up to two entries and releasing up to two entries per cycle.
module instr_queue #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned VLEN  = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic [1:0]           valid_i,
  input  logic [1:0][VLEN-1:0] addr_i,
  input  logic [1:0][31:0]     instr_i,
  input  logic [1:0]           is_compressed_i,
  output logic                 ready_o,
  output logic [1:0]           valid_o,
  output logic [1:0][VLEN-1:0] addr_o,
  output logic [1:0][31:0]     instr_o,
  output logic [1:0]           is_compressed_o,
  input  logic [1:0]           ack_i,
  output logic                 empty_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [PtrW:0]   cnt_t;

  localparam cnt_t ReadyMax = cnt_t'(DEPTH - 2);

  ptr_t rd_ptr_q, rd_ptr_d;
  ptr_t wr_ptr_q, wr_ptr_d;
  cnt_t count_q, count_d;
  ptr_t rd_ptr_nxt, wr_ptr_nxt;

  logic [VLEN-1:0] addr_mem  [DEPTH];
  logic [31:0]     instr_mem [DEPTH];
  logic            comp_mem  [DEPTH];

  logic [1:0] num_push;
  logic [1:0] num_pop;

  assign rd_ptr_nxt = rd_ptr_q + ptr_t'(1);
  assign wr_ptr_nxt = wr_ptr_q + ptr_t'(1);

  // Status derives from registered count only, so a same-cycle pop never raises ready.
  assign ready_o    = (count_q <= ReadyMax);
  assign empty_o    = (count_q == '0);
  assign valid_o[0] = (count_q != '0);
  assign valid_o[1] = (count_q >= cnt_t'(2));

  always_comb begin
    num_push = 2'd0;
    if (ready_o && !flush_i) begin
      unique case (valid_i)
        2'b01:   num_push = 2'd1;
        2'b11:   num_push = 2'd2;
        default: num_push = 2'd0;
      endcase
    end
  end

  always_comb begin
    num_pop = 2'd0;
    if (!flush_i && ack_i[0] && valid_o[0]) begin
      num_pop = (ack_i[1] && valid_o[1]) ? 2'd2 : 2'd1;
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q + ptr_t'(num_pop);
    wr_ptr_d = wr_ptr_q + ptr_t'(num_push);
    count_d  = count_q + cnt_t'(num_push) - cnt_t'(num_pop);
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; valid_o masks stale contents.
  always_ff @(posedge clk_i) begin
    if (!rst_i && num_push != 2'd0) begin
      addr_mem[wr_ptr_q]  <= addr_i[0];
      instr_mem[wr_ptr_q] <= instr_i[0];
      comp_mem[wr_ptr_q]  <= is_compressed_i[0];
      if (num_push == 2'd2) begin
        addr_mem[wr_ptr_nxt]  <= addr_i[1];
        instr_mem[wr_ptr_nxt] <= instr_i[1];
        comp_mem[wr_ptr_nxt]  <= is_compressed_i[1];
      end
    end
  end

  always_comb begin
    addr_o          = '0;
    instr_o         = '0;
    is_compressed_o = '0;
    if (valid_o[0]) begin
      addr_o[0]          = addr_mem[rd_ptr_q];
      instr_o[0]         = instr_mem[rd_ptr_q];
      is_compressed_o[0] = comp_mem[rd_ptr_q];
    end
    if (valid_o[1]) begin
      addr_o[1]          = addr_mem[rd_ptr_nxt];
      instr_o[1]         = instr_mem[rd_ptr_nxt];
      is_compressed_o[1] = comp_mem[rd_ptr_nxt];
    end
  end

endmodule

// File: tb/tb_instr_queue.sv
// Self-checking bench for instr_queue: queue-based reference model, one task per scenario.
module tb_instr_queue;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned VLEN  = 64;

  logic                 clk = 1'b0;
  logic                 rst, flush;
  logic [1:0]           vin, ack, cin;
  logic [1:0][VLEN-1:0] ain;
  logic [1:0][31:0]     iin;
  logic                 ready, empty;
  logic [1:0]           vout, cout;
  logic [1:0][VLEN-1:0] aout;
  logic [1:0][31:0]     iout;

  typedef struct {
    logic [VLEN-1:0] a;
    logic [31:0]     i;
    logic            c;
  } ent_t;

  ent_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  instr_queue #(.DEPTH(DEPTH), .VLEN(VLEN)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .flush_i        (flush),
    .valid_i        (vin),
    .addr_i         (ain),
    .instr_i        (iin),
    .is_compressed_i(cin),
    .ready_o        (ready),
    .valid_o        (vout),
    .addr_o         (aout),
    .instr_o        (iout),
    .is_compressed_o(cout),
    .ack_i          (ack),
    .empty_o        (empty)
  );

  function automatic logic [1:0] exp_valid();
    return {sb.size() >= 2, sb.size() >= 1};
  endfunction

  function automatic logic exp_ready();
    return (int'(DEPTH) - sb.size()) >= 2;
  endfunction

  // Drive one cycle of stimulus and advance the reference model across the edge.
  task automatic step(input logic fl, input logic [1:0] v, input logic [1:0] ak,
                      input logic [1:0][VLEN-1:0] a, input logic [1:0][31:0] ins,
                      input logic [1:0] c);
    int   n;
    int   pops;
    logic rdy;
    ent_t e;
    flush = fl; vin = v; ack = ak; ain = a; iin = ins; cin = c;
    n    = sb.size();
    rdy  = (int'(DEPTH) - n) >= 2;
    pops = 0;
    if (ak[0] && n >= 1) pops = (ak[1] && n >= 2) ? 2 : 1;
    @(posedge clk); #1;
    if (fl) begin
      sb.delete();
    end else begin
      repeat (pops) sb.delete(0);
      if (rdy && v[0]) begin
        e.a = a[0]; e.i = ins[0]; e.c = c[0];
        sb.push_back(e);
        if (v[1]) begin
          e.a = a[1]; e.i = ins[1]; e.c = c[1];
          sb.push_back(e);
        end
      end
    end
    flush = 1'b0; vin = 2'b00; ack = 2'b00;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; vin = 2'b11; ack = 2'b11;
    ain = {64'hdead, 64'hbeef}; iin = {32'h1111, 32'h2222}; cin = 2'b11;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0; vin = 2'b00; ack = 2'b00;
    sb.delete();
    n_checks++; if (vout !== 2'b00) begin n_fail++; $display("FAIL reset_valid: got %b want 00", vout); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty); end
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ready); end
    n_checks++;
    if (aout !== '0 || iout !== '0 || cout !== 2'b00) begin
      n_fail++; $display("FAIL reset_data: got addr %h instr %h c %b want zeros", aout, iout, cout);
    end
  endtask

  task automatic test_single_push();
    step(1'b0, 2'b11, 2'b00, {64'h1002, 64'h1000}, {32'h00008082, 32'h00004501}, 2'b11);
    n_checks++; if (vout !== 2'b11) begin n_fail++; $display("FAIL single_valid: got %b want 11", vout); end
    n_checks++;
    if (aout !== {64'h1002, 64'h1000}) begin
      n_fail++; $display("FAIL single_addr: got %h want 1002/1000", aout);
    end
    n_checks++;
    if (iout !== {32'h00008082, 32'h00004501} || cout !== 2'b11) begin
      n_fail++; $display("FAIL single_instr: got %h c %b want 00008082_00004501 c 11", iout, cout);
    end
    n_checks++;
    if (empty !== 1'b0 || ready !== 1'b1) begin
      n_fail++; $display("FAIL single_status: got empty %b ready %b want 0 1", empty, ready);
    end
    step(1'b0, 2'b00, 2'b11, '0, '0, 2'b00);
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL single_drain: got empty %b want 1", empty); end
  endtask

  task automatic test_fill();
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 2'b11, 2'b00, {64'(16'h3000 + 4 * k + 2), 64'(16'h3000 + 4 * k)},
           {32'(32'hF0 + 2 * k + 1), 32'(32'hF0 + 2 * k)}, 2'b00);
      n_checks++;
      if (ready !== exp_ready()) begin
        n_fail++; $display("FAIL fill_ready_%0d: got %b want %b", k, ready, exp_ready());
      end
    end
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b want 0", ready); end
    step(1'b0, 2'b11, 2'b00, {64'h9999, 64'h8888}, {32'h77, 32'h66}, 2'b11);
    n_checks++;
    if (iout !== {32'h000000F1, 32'h000000F0} || vout !== 2'b11 || ready !== 1'b0) begin
      n_fail++; $display("FAIL full_drop: got instr %h valid %b ready %b want F1/F0 11 0",
                         iout, vout, ready);
    end
    // Reset while full, with flush, push and ack all active.
    rst = 1'b1; flush = 1'b1; vin = 2'b11; ack = 2'b11;
    @(posedge clk); #1;
    rst = 1'b0; flush = 1'b0; vin = 2'b00; ack = 2'b00;
    sb.delete();
    n_checks++;
    if (vout !== 2'b00 || empty !== 1'b1 || ready !== 1'b1 || iout !== '0) begin
      n_fail++; $display("FAIL full_reset: got valid %b empty %b ready %b instr %h want 00 1 1 0",
                         vout, empty, ready, iout);
    end
  endtask

  task automatic test_concurrent();
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 2'b01, 2'b00, {64'h0, 64'(16'h2000 + 2 * k)}, {32'h0, 32'(32'hA0 + k)}, 2'b00);
    end
    step(1'b0, 2'b11, 2'b11, {64'h2008, 64'h2006}, {32'hA4, 32'hA3}, 2'b10);
    n_checks++;
    if (iout !== {32'hA3, 32'hA2} || vout !== 2'b11) begin
      n_fail++; $display("FAIL concurrent_head: got %h valid %b want A3/A2 11", iout, vout);
    end
    n_checks++;
    if (aout[0] !== 64'h2004) begin
      n_fail++; $display("FAIL concurrent_addr: got %h want 2004", aout[0]);
    end
    step(1'b0, 2'b00, 2'b11, '0, '0, 2'b00);
    n_checks++;
    if (vout !== 2'b01 || iout[0] !== 32'hA4 || cout[0] !== 1'b1) begin
      n_fail++; $display("FAIL concurrent_tail: got valid %b instr %h c %b want 01 A4 1",
                         vout, iout[0], cout[0]);
    end
    step(1'b0, 2'b00, 2'b01, '0, '0, 2'b00);
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL concurrent_drain: got %b want 1", empty); end
  endtask

  task automatic test_illegal();
    step(1'b0, 2'b10, 2'b00, {64'h55, 64'h44}, {32'h55, 32'h44}, 2'b00);
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL valid10_push: got empty %b want 1", empty); end
    step(1'b0, 2'b01, 2'b00, {64'h0, 64'h4000}, {32'h0, 32'hC0DE}, 2'b01);
    step(1'b0, 2'b00, 2'b10, '0, '0, 2'b00);
    n_checks++;
    if (vout !== 2'b01 || iout[0] !== 32'hC0DE) begin
      n_fail++; $display("FAIL ack10_pop: got valid %b instr %h want 01 C0DE", vout, iout[0]);
    end
    step(1'b0, 2'b00, 2'b11, '0, '0, 2'b00);
    n_checks++;
    if (empty !== 1'b1 || vout !== 2'b00 || ready !== 1'b1) begin
      n_fail++; $display("FAIL ack11_count1: got empty %b valid %b ready %b want 1 00 1",
                         empty, vout, ready);
    end
  endtask

  task automatic test_flush();
    step(1'b0, 2'b11, 2'b00, {64'h5002, 64'h5000}, {32'hB1, 32'hB0}, 2'b00);
    step(1'b0, 2'b11, 2'b00, {64'h5006, 64'h5004}, {32'hB3, 32'hB2}, 2'b00);
    step(1'b1, 2'b11, 2'b01, {64'h500A, 64'h5008}, {32'hB5, 32'hB4}, 2'b00);
    n_checks++;
    if (vout !== 2'b00 || empty !== 1'b1 || ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_state: got valid %b empty %b ready %b want 00 1 1",
                         vout, empty, ready);
    end
    step(1'b0, 2'b01, 2'b00, {64'h0, 64'h6000}, {32'h0, 32'hB6}, 2'b00);
    n_checks++;
    if (vout !== 2'b01 || iout[0] !== 32'hB6 || aout[0] !== 64'h6000) begin
      n_fail++; $display("FAIL flush_repush: got valid %b instr %h addr %h want 01 B6 6000",
                         vout, iout[0], aout[0]);
    end
    step(1'b0, 2'b00, 2'b01, '0, '0, 2'b00);
  endtask

  task automatic test_wrap_random();
    logic [1:0]           v, ak;
    logic [1:0][VLEN-1:0] a;
    logic [1:0][31:0]     ins;
    logic [1:0]           c;
    logic [31:0]          exp_i0;
    logic [VLEN-1:0]      exp_a0;
    for (int k = 0; k < 60; k++) begin
      v   = 2'($urandom_range(0, 3));
      ak  = 2'($urandom_range(0, 3));
      a   = {{$urandom, $urandom}, {$urandom, $urandom}};
      ins = {$urandom, $urandom};
      c   = 2'($urandom_range(0, 3));
      exp_i0 = (sb.size() >= 1) ? sb[0].i : 32'h0;
      exp_a0 = (sb.size() >= 1) ? sb[0].a : '0;
      n_checks++;
      if (vout !== exp_valid() || iout[0] !== exp_i0 || aout[0] !== exp_a0) begin
        n_fail++; $display("FAIL wrap_head_%0d: got valid %b instr %h addr %h want %b %h %h",
                           k, vout, iout[0], aout[0], exp_valid(), exp_i0, exp_a0);
      end
      if (sb.size() >= 2) begin
        n_checks++;
        if (iout[1] !== sb[1].i || cout[1] !== sb[1].c) begin
          n_fail++; $display("FAIL wrap_next_%0d: got %h c %b want %h c %b",
                             k, iout[1], cout[1], sb[1].i, sb[1].c);
        end
      end
      step(1'b0, v, ak, a, ins, c);
      n_checks++;
      if (ready !== exp_ready() || empty !== (sb.size() == 0) || sb.size() > int'(DEPTH)) begin
        n_fail++; $display("FAIL wrap_status_%0d: got ready %b empty %b want %b %b (model %0d)",
                           k, ready, empty, exp_ready(), sb.size() == 0, sb.size());
      end
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; vin = 2'b00; ack = 2'b00;
    ain = '0; iin = '0; cin = 2'b00;
    test_reset();
    test_single_push();
    test_fill();
    test_concurrent();
    test_illegal();
    test_flush();
    test_wrap_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
